sim_mem_mp: RTL and testbench
=============================

Name: sim_mem_mp

Overview:
Parametrised N-port byte-addressed simulation memory with configurable access latency. It is the next-generation Verilator backing store for the instruction and data caches and any extra masters.
- Each port runs an independent strobe/done handshake.
- Requests are captured at acceptance; writes honour byte enables.
- Out-of-range accesses are flagged on err_o.
- A verilator-public backdoor provides program loading and result inspection.

Parameters:
NUM_PORTS, 2, number of independent request ports (>=1)
ADDR_WIDTH, 32, byte-address width
DATA_WIDTH, 32, word width; multiple of 8; NB = DATA_WIDTH/8
MEM_SIZE, 32'h200000, bytes; power of two, >= NB; otherwise elaboration error
ACCESS_LATENCY, 0, extra wait cycles in ACCESS before the operation commits
OOR_RDATA, 32'hdeadbeef, read data returned for out-of-range reads (truncated/replicated to DATA_WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
strobe_i  in  [NUM_PORTS]  request pulse per port; sampled only in IDLE
addr_i  in  [NUM_PORTS][ADDR_WIDTH]  byte address
rw_i  in  [NUM_PORTS]  1 = write, 0 = read
wdata_i  in  [NUM_PORTS][DATA_WIDTH]  write data, little-endian byte order
be_i  in  [NUM_PORTS][NB]  write byte enables; ignored on reads
rdata_o  out  [NUM_PORTS][DATA_WIDTH]  read data; valid while done_o is high
done_o  out  [NUM_PORTS]  one-cycle completion pulse
err_o  out  [NUM_PORTS]  out-of-range flag, coincident with done_o
busy_o  out  [NUM_PORTS]  high whenever the port FSM is not IDLE

Behaviour:
- Reset (async assert, sync deassert by the system): all FSMs go to IDLE, counters to 0, rdata_o/done_o/err_o/busy_o to 0.
- The memory array is never reset. A write pending at reset is not committed.
- Per-port FSM states: IDLE, ACCESS, DONE.
- IDLE, strobe_i=1 at edge: capture addr/rw/wdata/be, go to ACCESS, counter=0.
- ACCESS, counter < ACCESS_LATENCY: counter increments.
- ACCESS, counter == ACCESS_LATENCY: commit the operation, go to DONE, drive done_o=1 (and err_o if out of range).
- DONE: go to IDLE unconditionally; done_o/err_o return to 0.
- Timing: done_o is high during cycle LAT+1 after the accepting edge. The next strobe is accepted in IDLE, giving back-to-back throughput of one request per LAT+3 cycles.
- Strobes in ACCESS or DONE are ignored; no queueing.
- Inputs may change after acceptance; only the captured values are used.
- Read: rdata_o = {mem[a+NB-1] .. mem[a]}. rdata_o holds that value until the next read completes on that port.
- Write: each mem[a+k] with be[k]=1 is updated. be=0 completes normally with no change.
- Out of range (a + NB > MEM_SIZE): writes are dropped; reads return OOR_RDATA; err_o=1. No wrap-around.
- Address arithmetic is at least ADDR_WIDTH+1 bits wide so the range check cannot overflow.
- Same-cycle writes from multiple ports to the same byte: the lowest port index wins.
- Same-cycle read and write to the same byte on different ports: the read returns the pre-write value (read-before-write).
- Misaligned addresses are legal; bytes are fetched individually.
- Backdoor (verilator public, zero time, no handshake interaction):
  - readWord(addr) returns OOR_RDATA when out of range.
  - writeWord(addr, val) ignores out-of-range addresses.
  - readByte(addr) returns 8'hef when out of range.
  - writeByte(addr, val) ignores out-of-range addresses.

Decomposition:
- Package sim_mem_pkg holds:
  - state_t enum {IDLE, ACCESS, DONE}
  - function in_range(addr, nb, size)
  - default OOR constants
- Sub-module sim_mem_port_fsm, generated once per port, owns the FSM, latency counter, captured request, done/err/busy and rdata registers. It emits a commit strobe plus captured request fields.
- The top owns the byte array, write-priority resolution, read mux and backdoor functions.

Test Plan:
- Reset: rst_n low mid-ACCESS with a write pending (addr 0x100, wdata 0x11223344) -> outputs 0, FSM IDLE, readWord(0x100) unchanged.
- Latency: ACCESS_LATENCY=3; port 0 read of 0x40 after writeWord(0x40, 0xCAFEBABE) -> done_o high exactly 4 cycles after the accepting edge, rdata_o=0xCAFEBABE, busy_o high for 5 cycles.
- Byte enables: mem 0x80 = 0xAABBCCDD; write 0x11223344 with be=4'b0101 -> readWord(0x80)=0xAA22CC44.
- Collision: port 0 and port 1 write 0x200 in the same cycle with 0x1 and 0x2 -> readWord(0x200)=0x1. Port 1 read of 0x200 simultaneous with a port 0 write -> port 1 returns the old value.
- Out of range: read at MEM_SIZE-2 with NB=4 -> err_o=1, rdata_o=0xDEADBEEF. Write at MEM_SIZE -> err_o=1, memory unchanged.
- Ignored strobe: strobe held high for 10 cycles with LAT=0 -> exactly 3 done pulses, spaced 3 cycles apart; addr changed after acceptance -> captured address used.

Source files
------------

// File: rtl/sim_mem_pkg.sv
// ----------------------------------------------------------------------------
// sim_mem_pkg
// Shared types and helpers for the multi-port simulation memory.
//   state_t            : per-port handshake FSM states
//   in_range()         : overflow-free range check for an access of nb bytes
//   OOR_*_DEFAULT      : data returned for out-of-range reads
// ----------------------------------------------------------------------------
package sim_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [31:0] OOR_RDATA_DEFAULT = 32'hdeadbeef;
    localparam logic [7:0]  OOR_BYTE_DEFAULT  = 8'hef;

    // 65-bit arithmetic: covers any ADDR_WIDTH up to 64 plus the carry of a + nb,
    // so an address near the top of the address space cannot wrap into range.
    function automatic logic in_range(input logic [64:0] addr,
                                      input int unsigned nb,
                                      input logic [64:0] size);
        return (addr + 65'(nb)) <= size;
    endfunction

endpackage

// File: rtl/sim_mem_mp_if.sv
// ----------------------------------------------------------------------------
// sim_mem_mp_if
// Bundle of per-port request/response signals for sim_mem_mp.
//   strobe_i/addr_i/rw_i/wdata_i/be_i : request, one lane per port
//   rdata_o/done_o/err_o/busy_o       : response, one lane per port
// Modports: master (requester side), slave (memory side).
// ----------------------------------------------------------------------------
interface sim_mem_mp_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int NB = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]                 strobe_i;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i;
    logic [NUM_PORTS-1:0]                 rw_i;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [NUM_PORTS-1:0][NB-1:0]         be_i;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_o;
    logic [NUM_PORTS-1:0]                 done_o;
    logic [NUM_PORTS-1:0]                 err_o;
    logic [NUM_PORTS-1:0]                 busy_o;

    modport master (
        output strobe_i, addr_i, rw_i, wdata_i, be_i,
        input  rdata_o, done_o, err_o, busy_o
    );

    modport slave (
        input  strobe_i, addr_i, rw_i, wdata_i, be_i,
        output rdata_o, done_o, err_o, busy_o
    );

endinterface

// File: rtl/sim_mem_port_fsm.sv
// ----------------------------------------------------------------------------
// sim_mem_port_fsm
// One request port: IDLE -> ACCESS (ACCESS_LATENCY wait cycles) -> DONE.
//   i_strobe/i_addr/i_rw/i_wdata/i_be : raw request, sampled only in IDLE
//   i_rdata   : word at o_addr from the shared array (OOR data already muxed)
//   o_commit  : high in the cycle whose closing edge commits the operation
//   o_addr/o_rw/o_wdata/o_be/o_inr : captured request fields for the array
//   o_rdata/o_done/o_err/o_busy    : registered port response
// ----------------------------------------------------------------------------
module sim_mem_port_fsm
    import sim_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned MEM_SIZE       = 32'h200000,
    parameter int          ACCESS_LATENCY = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_strobe,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic                    i_rw,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    o_commit,
    output logic [ADDR_WIDTH-1:0]   o_addr,
    output logic                    o_rw,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_be,
    output logic                    o_inr,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_done,
    output logic                    o_err,
    output logic                    o_busy
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = (ACCESS_LATENCY > 0) ? $clog2(ACCESS_LATENCY + 1) : 1;
    localparam logic [CW-1:0] LAT_C = CW'(ACCESS_LATENCY);

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rw;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]         r_be;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_done;
    logic                  r_err;
    logic                  r_busy;

    logic w_commit;
    logic w_inr;

    assign w_commit = (r_state == ACCESS) && (r_cnt == LAT_C);
    assign w_inr    = in_range(65'(r_addr), NB, 65'(MEM_SIZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_strobe) begin
                        r_addr  <= i_addr;
                        r_rw    <= i_rw;
                        r_wdata <= i_wdata;
                        r_be    <= i_be;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_commit) begin
                        // i_rdata is sampled at the same edge the array is written,
                        // so a colliding write on another port is not yet visible.
                        if (!r_rw) r_rdata <= i_rdata;
                        r_done  <= 1'b1;
                        r_err   <= ~w_inr;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_commit = w_commit;
    assign o_addr   = r_addr;
    assign o_rw     = r_rw;
    assign o_wdata  = r_wdata;
    assign o_be     = r_be;
    assign o_inr    = w_inr;
    assign o_rdata  = r_rdata;
    assign o_done   = r_done;
    assign o_err    = r_err;
    assign o_busy   = r_busy;

endmodule

// File: rtl/sim_mem_mp.sv
// ----------------------------------------------------------------------------
// sim_mem_mp
// N-port byte-addressed simulation memory with configurable access latency.
//   clk, rst_n : clock, asynchronous active-low reset (array is never reset)
//   bus        : sim_mem_mp_if.slave, one strobe/done handshake per port
// Backdoor: readWord/writeWord/readByte/writeByte act on the array in zero
// time and never touch the port FSMs.
// ----------------------------------------------------------------------------
module sim_mem_mp
    import sim_mem_pkg::*;
#(
    parameter int          NUM_PORTS      = 2,
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned MEM_SIZE       = 32'h200000,
    parameter int          ACCESS_LATENCY = 0,
    parameter logic [31:0] OOR_RDATA      = OOR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    sim_mem_mp_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int MW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    if (NUM_PORTS < 1) begin : g_bad_ports
        $error("sim_mem_mp: NUM_PORTS must be >= 1");
    end
    if ((DATA_WIDTH < 8) || (DATA_WIDTH % 8 != 0)) begin : g_bad_width
        $error("sim_mem_mp: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (((MEM_SIZE & (MEM_SIZE - 1)) != 0) || (MEM_SIZE < NB)) begin : g_bad_size
        $error("sim_mem_mp: MEM_SIZE must be a power of two and >= NB");
    end

    // OOR_RDATA replicated (or truncated) to the word width.
    function automatic logic [DATA_WIDTH-1:0] f_oor_word();
        logic [DATA_WIDTH-1:0] w;
        for (int i = 0; i < DATA_WIDTH; i++) w[i] = OOR_RDATA[i % 32];
        return w;
    endfunction
    localparam logic [DATA_WIDTH-1:0] OOR_WORD = f_oor_word();

    logic [7:0] r_mem [MEM_SIZE];

    logic [NUM_PORTS-1:0]                 w_commit;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] w_addr;
    logic [NUM_PORTS-1:0]                 w_rw;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_wdata;
    logic [NUM_PORTS-1:0][NB-1:0]         w_be;
    logic [NUM_PORTS-1:0]                 w_inr;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [DATA_WIDTH-1:0] w_rd;

        // Bytes are fetched individually so misaligned addresses need no special case.
        always_comb begin
            w_rd = OOR_WORD;
            if (w_inr[p]) begin
                for (int k = 0; k < NB; k++)
                    w_rd[8*k +: 8] = r_mem[MW'(w_addr[p]) + MW'(k)];
            end
        end

        sim_mem_port_fsm #(
            .ADDR_WIDTH     (ADDR_WIDTH),
            .DATA_WIDTH     (DATA_WIDTH),
            .MEM_SIZE       (MEM_SIZE),
            .ACCESS_LATENCY (ACCESS_LATENCY)
        ) u_fsm (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_strobe (bus.strobe_i[p]),
            .i_addr   (bus.addr_i[p]),
            .i_rw     (bus.rw_i[p]),
            .i_wdata  (bus.wdata_i[p]),
            .i_be     (bus.be_i[p]),
            .i_rdata  (w_rd),
            .o_commit (w_commit[p]),
            .o_addr   (w_addr[p]),
            .o_rw     (w_rw[p]),
            .o_wdata  (w_wdata[p]),
            .o_be     (w_be[p]),
            .o_inr    (w_inr[p]),
            .o_rdata  (bus.rdata_o[p]),
            .o_done   (bus.done_o[p]),
            .o_err    (bus.err_o[p]),
            .o_busy   (bus.busy_o[p])
        );
    end

    // Plain always: the backdoor functions also write this array.
    // Ports are walked from highest to lowest so the lowest index's write
    // is the last one scheduled and wins on a same-byte collision.
    always @(posedge clk) begin
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (w_commit[p] && w_rw[p] && w_inr[p]) begin
                for (int k = 0; k < NB; k++) begin
                    if (w_be[p][k])
                        r_mem[MW'(w_addr[p]) + MW'(k)] <= w_wdata[p][8*k +: 8];
                end
            end
        end
    end

    // ---------------- backdoor ----------------
    function automatic logic [DATA_WIDTH-1:0] readWord(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] w;
        if (!in_range(65'(addr), NB, 65'(MEM_SIZE))) return OOR_WORD;
        for (int k = 0; k < NB; k++) w[8*k +: 8] = r_mem[MW'(addr) + MW'(k)];
        return w;
    endfunction

    function automatic void writeWord(input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [DATA_WIDTH-1:0] val);
        if (in_range(65'(addr), NB, 65'(MEM_SIZE))) begin
            for (int k = 0; k < NB; k++) r_mem[MW'(addr) + MW'(k)] = val[8*k +: 8];
        end
    endfunction

    function automatic logic [7:0] readByte(input logic [ADDR_WIDTH-1:0] addr);
        if (!in_range(65'(addr), 1, 65'(MEM_SIZE))) return OOR_BYTE_DEFAULT;
        return r_mem[MW'(addr)];
    endfunction

    function automatic void writeByte(input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [7:0] val);
        if (in_range(65'(addr), 1, 65'(MEM_SIZE))) r_mem[MW'(addr)] = val;
    endfunction

endmodule

// File: tb/tb_sim_mem_mp.sv
// ----------------------------------------------------------------------------
// tb_sim_mem_mp
// Self-checking bench: dut_a (latency 3) carries most scenarios, dut_b
// (latency 0) carries the held-strobe throughput scenario. Expected port
// responses are queued when a request is issued and popped on completion.
// ----------------------------------------------------------------------------
module tb_sim_mem_mp;
    localparam int unsigned MEM = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    sim_mem_mp_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    sim_mem_mp_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

    sim_mem_mp #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(MEM),
                 .ACCESS_LATENCY(3), .OOR_RDATA(32'hdeadbeef))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    sim_mem_mp #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(MEM),
                 .ACCESS_LATENCY(0), .OOR_RDATA(32'hdeadbeef))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Drive a request on the ports in en (same cycle), scramble inputs right
    // after acceptance, then collect responses. lat/bsy refer to the lowest
    // enabled port; lat counts edges from the accepting edge to done.
    task automatic run_a(input logic [1:0] en, input logic [1:0] rw,
                         input logic [1:0][31:0] addr, input logic [1:0][31:0] wd,
                         input logic [1:0][3:0] be,
                         output logic [1:0][31:0] rd, output logic [1:0] er,
                         output int lat, output int bsy, output bit tmo);
        logic [1:0] got;
        int pp;
        got = '0; rd = '0; er = '0; lat = -1; bsy = 0;
        pp = en[0] ? 0 : 1;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (en[p]) begin
                bus_a.strobe_i[p] = 1'b1;
                bus_a.rw_i[p]     = rw[p];
                bus_a.addr_i[p]   = addr[p];
                bus_a.wdata_i[p]  = wd[p];
                bus_a.be_i[p]     = be[p];
            end
        end
        @(negedge clk);
        bus_a.strobe_i = '0;
        bus_a.addr_i   = {2{32'h300}};
        bus_a.wdata_i  = ~wd;
        bus_a.be_i     = ~be;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            if (bus_a.busy_o[pp]) bsy++;
            for (int p = 0; p < 2; p++) begin
                if (en[p] && !got[p] && bus_a.done_o[p]) begin
                    got[p] = 1'b1;
                    rd[p]  = bus_a.rdata_o[p];
                    er[p]  = bus_a.err_o[p];
                    if (p == pp) lat = i;
                end
            end
            if (got == en && bus_a.busy_o == 2'b00) break;
        end
        tmo = (got != en);
    endtask

    task automatic test_reset();
        int dones;
        n_tests++;
        if ({bus_a.rdata_o, bus_a.done_o, bus_a.err_o, bus_a.busy_o,
             bus_b.rdata_o, bus_b.done_o, bus_b.err_o, bus_b.busy_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got a=%h/%b/%b/%b want all zero",
                     bus_a.rdata_o, bus_a.done_o, bus_a.err_o, bus_a.busy_o);
        end
        dut_a.writeWord(32'h100, 32'h55667788);
        @(negedge clk);
        bus_a.strobe_i[0] = 1'b1; bus_a.rw_i[0] = 1'b1; bus_a.addr_i[0] = 32'h100;
        bus_a.wdata_i[0] = 32'h11223344; bus_a.be_i[0] = 4'hf;
        @(negedge clk);
        bus_a.strobe_i[0] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus_a.busy_o[0] !== 1'b1) begin
            n_fail++; $display("FAIL reset_inflight_busy: got %b want 1", bus_a.busy_o[0]);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus_a.rdata_o, bus_a.done_o, bus_a.err_o, bus_a.busy_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_midaccess_outputs: got %h/%b/%b/%b want zero",
                     bus_a.rdata_o, bus_a.done_o, bus_a.err_o, bus_a.busy_o);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_a.done_o != 2'b00 || bus_a.busy_o != 2'b00) dones++;
        end
        n_tests++;
        if (dones !== 0) begin
            n_fail++; $display("FAIL reset_fsm_idle: %0d active cycles after reset, want 0", dones);
        end
        n_tests++;
        if (dut_a.readWord(32'h100) !== 32'h55667788) begin
            n_fail++;
            $display("FAIL reset_no_commit: mem[0x100]=%h want 55667788", dut_a.readWord(32'h100));
        end
    endtask

    task automatic test_latency();
        logic [1:0][31:0] rd; logic [1:0] er; int lat, bsy; bit tmo; exp_t e;
        dut_a.writeWord(32'h40, 32'hCAFEBABE);
        exp_q.push_back('{rdata: 32'hCAFEBABE, err: 1'b0});
        run_a(2'b01, 2'b00, {32'h0, 32'h40}, '0, '0, rd, er, lat, bsy, tmo);
        e = exp_q.pop_front();
        n_tests++;
        if (tmo) begin n_fail++; $display("FAIL latency_timeout: no done_o within bound"); end
        n_tests++;
        if (rd[0] !== e.rdata || er[0] !== e.err) begin
            n_fail++; $display("FAIL latency_rdata: got %h err %b want %h err %b", rd[0], er[0], e.rdata, e.err);
        end
        n_tests++;
        if (lat !== 4) begin n_fail++; $display("FAIL latency_cycles: got %0d want 4", lat); end
        n_tests++;
        if (bsy !== 5) begin n_fail++; $display("FAIL latency_busy: got %0d want 5", bsy); end
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus_a.rdata_o[0] !== 32'hCAFEBABE) begin
            n_fail++; $display("FAIL latency_rdata_hold: got %h want cafebabe", bus_a.rdata_o[0]);
        end
    endtask

    task automatic test_byte_en();
        logic [1:0][31:0] rd; logic [1:0] er; int lat, bsy; bit tmo;
        dut_a.writeWord(32'h80, 32'hAABBCCDD);
        run_a(2'b10, 2'b10, {32'h80, 32'h0}, {32'h11223344, 32'h0}, {4'b0101, 4'h0},
              rd, er, lat, bsy, tmo);
        n_tests++;
        if (tmo || er[1] !== 1'b0 || dut_a.readWord(32'h80) !== 32'hAA22CC44) begin
            n_fail++;
            $display("FAIL byte_en: mem=%h err=%b tmo=%b want aa22cc44 err 0",
                     dut_a.readWord(32'h80), er[1], tmo);
        end
        run_a(2'b01, 2'b01, {32'h0, 32'h80}, {32'h0, 32'hFFFFFFFF}, {4'h0, 4'h0},
              rd, er, lat, bsy, tmo);
        n_tests++;
        if (tmo || er[0] !== 1'b0 || dut_a.readWord(32'h80) !== 32'hAA22CC44) begin
            n_fail++;
            $display("FAIL byte_en_zero: mem=%h err=%b tmo=%b want aa22cc44 err 0",
                     dut_a.readWord(32'h80), er[0], tmo);
        end
    endtask

    task automatic test_collision();
        logic [1:0][31:0] rd; logic [1:0] er; int lat, bsy; bit tmo; exp_t e;
        run_a(2'b11, 2'b11, {32'h200, 32'h200}, {32'h2, 32'h1}, {4'hf, 4'hf},
              rd, er, lat, bsy, tmo);
        n_tests++;
        if (tmo || dut_a.readWord(32'h200) !== 32'h1) begin
            n_fail++; $display("FAIL collision_priority: mem=%h want 00000001", dut_a.readWord(32'h200));
        end
        exp_q.push_back('{rdata: 32'h1, err: 1'b0});
        run_a(2'b11, 2'b01, {32'h200, 32'h200}, {32'h0, 32'h77}, {4'h0, 4'hf},
              rd, er, lat, bsy, tmo);
        e = exp_q.pop_front();
        n_tests++;
        if (tmo || rd[1] !== e.rdata || er[1] !== e.err) begin
            n_fail++; $display("FAIL collision_rbw: port1 got %h want %h", rd[1], e.rdata);
        end
        n_tests++;
        if (dut_a.readWord(32'h200) !== 32'h77) begin
            n_fail++; $display("FAIL collision_write: mem=%h want 00000077", dut_a.readWord(32'h200));
        end
    endtask

    task automatic test_oor();
        logic [1:0][31:0] rd; logic [1:0] er; int lat, bsy; bit tmo; exp_t e;
        dut_a.writeWord(32'h0, 32'h01020304);
        dut_a.writeWord(MEM - 4, 32'hA5A5A5A5);
        exp_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b1});
        run_a(2'b01, 2'b00, {32'h0, MEM - 2}, '0, '0, rd, er, lat, bsy, tmo);
        e = exp_q.pop_front();
        n_tests++;
        if (tmo || rd[0] !== e.rdata || er[0] !== e.err) begin
            n_fail++; $display("FAIL oor_read: got %h err %b want %h err %b", rd[0], er[0], e.rdata, e.err);
        end
        exp_q.push_back('{rdata: 32'hA5A5A5A5, err: 1'b0});
        run_a(2'b10, 2'b00, {MEM - 4, 32'h0}, '0, '0, rd, er, lat, bsy, tmo);
        e = exp_q.pop_front();
        n_tests++;
        if (tmo || rd[1] !== e.rdata || er[1] !== e.err) begin
            n_fail++; $display("FAIL oor_last_word: got %h err %b want %h err %b", rd[1], er[1], e.rdata, e.err);
        end
        run_a(2'b01, 2'b01, {32'h0, MEM}, {32'h0, 32'hFFFFFFFF}, {4'h0, 4'hf},
              rd, er, lat, bsy, tmo);
        n_tests++;
        if (tmo || er[0] !== 1'b1 || dut_a.readWord(32'h0) !== 32'h01020304
            || dut_a.readWord(MEM - 4) !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL oor_write: err=%b mem0=%h memtop=%h want err 1, 01020304, a5a5a5a5",
                     er[0], dut_a.readWord(32'h0), dut_a.readWord(MEM - 4));
        end
        n_tests++;
        if (dut_a.readWord(MEM - 2) !== 32'hDEADBEEF || dut_a.readByte(MEM) !== 8'hEF) begin
            n_fail++;
            $display("FAIL oor_backdoor: word=%h byte=%h want deadbeef ef",
                     dut_a.readWord(MEM - 2), dut_a.readByte(MEM));
        end
        dut_a.writeByte(32'h1, 8'h99);
        n_tests++;
        if (dut_a.readWord(32'h0) !== 32'h01029904 || dut_a.readByte(MEM - 1) !== 8'hA5) begin
            n_fail++;
            $display("FAIL backdoor_byte: word0=%h top=%h want 01029904 a5",
                     dut_a.readWord(32'h0), dut_a.readByte(MEM - 1));
        end
    endtask

    task automatic test_misaligned_capture();
        logic [1:0][31:0] rd; logic [1:0] er; int lat, bsy; bit tmo; exp_t e;
        dut_a.writeWord(32'h10, 32'h44332211);
        dut_a.writeWord(32'h14, 32'h88776655);
        exp_q.push_back('{rdata: 32'h66554433, err: 1'b0});
        run_a(2'b01, 2'b00, {32'h0, 32'h12}, '0, '0, rd, er, lat, bsy, tmo);
        e = exp_q.pop_front();
        n_tests++;
        if (tmo || rd[0] !== e.rdata || er[0] !== e.err) begin
            n_fail++; $display("FAIL misaligned: got %h want %h", rd[0], e.rdata);
        end
        // run_a moves addr_i to 0x300 right after acceptance
        dut_a.writeWord(32'h300, 32'h0BADF00D);
        dut_a.writeWord(32'h340, 32'h13579BDF);
        exp_q.push_back('{rdata: 32'h13579BDF, err: 1'b0});
        run_a(2'b10, 2'b00, {32'h340, 32'h0}, '0, '0, rd, er, lat, bsy, tmo);
        e = exp_q.pop_front();
        n_tests++;
        if (tmo || rd[1] !== e.rdata) begin
            n_fail++; $display("FAIL capture_addr: got %h want %h", rd[1], e.rdata);
        end
    endtask

    task automatic test_back_to_back();
        int dn, last, gap_bad;
        bit idle;
        dn = 0; last = -1; gap_bad = 0; idle = 1'b0;
        @(negedge clk);
        bus_b.strobe_i[0] = 1'b1; bus_b.rw_i[0] = 1'b0; bus_b.addr_i[0] = 32'h20;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_b.done_o[0]) begin
                if (last >= 0 && i - last != 3) gap_bad++;
                last = i;
                dn++;
            end
        end
        bus_b.strobe_i[0] = 1'b0;
        n_tests++;
        if (dn !== 3) begin n_fail++; $display("FAIL strobe_done_count: got %0d want 3", dn); end
        n_tests++;
        if (gap_bad !== 0) begin n_fail++; $display("FAIL strobe_spacing: %0d gaps differ from 3", gap_bad); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus_b.busy_o[0]) begin idle = 1'b1; break; end
        end
        n_tests++;
        if (!idle) begin n_fail++; $display("FAIL strobe_drain: busy_o still 1 after bound"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.strobe_i = '0; bus_a.addr_i = '0; bus_a.rw_i = '0; bus_a.wdata_i = '0; bus_a.be_i = '0;
        bus_b.strobe_i = '0; bus_b.addr_i = '0; bus_b.rw_i = '0; bus_b.wdata_i = '0; bus_b.be_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_latency();
        test_byte_en();
        test_collision();
        test_oor();
        test_misaligned_capture();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
